// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART serial receiver and the bus.
// Captures each byte from the receiver through a ready/ack handshake and
// stores it in a synchronous FIFO. The bus side sees the bytes through a
// show-ahead read port. The block also reports the fill level and a sticky
// overrun flag that is set when a byte is dropped.
// Optional feature: define UART_RX_FIFO_IRQ_EN to add threshold_i and a
// registered level interrupt irq_o.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_ready_i,
    output logic                  rx_ack_o,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overrun_o,
    input  logic                  clear_overrun_i
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    input  logic [DEPTH_LOG2:0]   threshold_i,
    output logic                  irq_o
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_LOW = 2'd2
    } cap_state_e;

    cap_state_e              state_q;
    logic                    ack_q;

    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overrun_q, overrun_d;

    logic                    capture;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // Count never exceeds DEPTH, so its MSB alone marks the full state.
    assign empty   = (count_q == '0);
    assign full    = count_q[DEPTH_LOG2];
    assign capture = (state_q == S_IDLE) && rx_ready_i;
    assign pop     = rd_i && !empty;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Capture handshake: one ack pulse per byte, then wait for ready to drop.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_ready_i) begin
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!rx_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Next-state of pointers, fill count and overrun flag (set beats clear).
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO control state registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is left unreset; contents only matter once counted in.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wptr_q] <= rx_data_i;
        end
    end

    assign rx_ack_o   = ack_q;
    assign rd_data_o  = mem_q[rptr_q];
    assign rd_valid_o = !empty;
    assign count_o    = count_q;
    assign overrun_o  = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_q;

    // Level interrupt on fill threshold (zero disables it) or on overrun.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ((threshold_i != '0) && (count_q >= threshold_i)) || overrun_q;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule
